// File: rtl/fwd_pkg.sv
// fwd_pkg: selector encodings, destination-record type and default index width shared by the forwarding unit
package fwd_pkg;
  localparam int FWD_REG_IDX_W = 4;
  localparam logic [1:0] FWD_SEL_REGFILE = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB   = 2'b10;
  localparam logic [1:0] FWD_SEL_ZERO    = 2'b11;
  typedef struct packed {
    logic                     valid;
    logic [FWD_REG_IDX_W-1:0] rd;
    logic                     we;
    logic                     is_load;
  } dst_rec_t;
endpackage

// File: rtl/fwd_operand_match.sv
// fwd_operand_match: compares one source operand against the EX and MEM destination records
module fwd_operand_match
  import fwd_pkg::*;
(
  input  logic [FWD_REG_IDX_W-1:0] rs,
  input  logic                     used,
  input  dst_rec_t                 r1,
  input  dst_rec_t                 r2,
  output logic [1:0]               sel,
  output logic                     load_hit
);
  logic hit1, hit2;
  assign hit1     = used & r1.valid & r1.we & (rs == r1.rd);
  assign hit2     = used & r2.valid & r2.we & (rs == r2.rd);
  assign load_hit = hit1 & r1.is_load;
  assign sel      = (hit1 & !r1.is_load) ? FWD_SEL_EXMEM : hit2 ? FWD_SEL_MEMWB : FWD_SEL_REGFILE;
endmodule

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: EX operand-forward selectors and load-use stall; perf counters enabled by FWD_PERF_CNT_EN
module fwd_ctrl_unit
  import fwd_pkg::*;
#(
  parameter int REG_IDX_W = FWD_REG_IDX_W,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_en,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic                 id_rs1_used,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_rd_we,
  input  logic                 id_is_load,
  output logic [1:0]           ex_sel_a,
  output logic [1:0]           ex_sel_b,
  output logic                 load_use_stall,
  output logic [CNT_W-1:0]     perf_fwd_cnt,
  output logic [CNT_W-1:0]     perf_stall_cnt
);
  dst_rec_t   r1_q, r1_d, r2_q, r2_d, id_rec;
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d, sel_a, sel_b;
  logic       lh_a, lh_b, kill;

  fwd_operand_match u_match_a (.rs(id_rs1), .used(id_rs1_used), .r1(r1_q), .r2(r2_q), .sel(sel_a), .load_hit(lh_a));
  fwd_operand_match u_match_b (.rs(id_rs2), .used(id_rs2_used), .r1(r1_q), .r2(r2_q), .sel(sel_b), .load_hit(lh_b));

  assign load_use_stall = id_valid & !flush & (lh_a | lh_b);
  assign kill           = flush | load_use_stall;
  assign id_rec         = '{valid: id_valid, rd: id_rd, we: id_rd_we, is_load: id_is_load};
  assign ex_sel_a       = sel_a_q;
  assign ex_sel_b       = sel_b_q;

  // Advance the record pipeline; a flush or stall injects a bubble with regfile selects
  always_comb begin
    r2_d    = pipe_en ? r1_q : r2_q;
    r1_d    = pipe_en ? (kill ? '0 : id_rec) : r1_q;
    sel_a_d = pipe_en ? (kill ? FWD_SEL_REGFILE : sel_a) : sel_a_q;
    sel_b_d = pipe_en ? (kill ? FWD_SEL_REGFILE : sel_b) : sel_b_q;
  end

  // Record and selector registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q    <= '0;
      r2_q    <= '0;
      sel_a_q <= FWD_SEL_REGFILE;
      sel_b_q <= FWD_SEL_REGFILE;
    end else begin
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;
  logic             adv;
  assign adv = pipe_en & !kill;

  // Count forwarded operands on advancing edges and stall cycles on enabled edges
  always_comb begin
    fwd_cnt_d   = fwd_cnt_q + (adv ? CNT_W'(sel_a != FWD_SEL_REGFILE) + CNT_W'(sel_b != FWD_SEL_REGFILE) : '0);
    stall_cnt_d = stall_cnt_q + CNT_W'(pipe_en & load_use_stall);
  end

  // Counter registers, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fwd_cnt   = fwd_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fwd_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: doc/fwd_ctrl_unit.md
Name: fwd_ctrl_unit

Overview:
- Operand-forwarding and load-use hazard controller for the eBPF CPU core pipeline.
- Tracks destination-register records of in-flight instructions and produces registered 2-bit selectors for the two 64-bit EX-stage operand muxes.
- Mux inputs: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result, 11 = zero.
- Raises a stall request when a load result is consumed by the next instruction.

Parameters:
- REG_IDX_W, 4, register index width (eBPF r0..r10).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- pipe_en  in  1  pipeline advance; 0 freezes all state (memory wait).
- flush  in  1  squash instruction currently in ID (taken branch resolved in EX).
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_IDX_W  source 1 index.
- id_rs1_used  in  1  source 1 is read.
- id_rs2  in  REG_IDX_W  source 2 index.
- id_rs2_used  in  1  source 2 is read.
- id_rd  in  REG_IDX_W  destination index.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a memory load.
- ex_sel_a  out  2  operand A mux selector, valid during EX.
- ex_sel_b  out  2  operand B mux selector, valid during EX.
- load_use_stall  out  1  hold PC/IF/ID, insert bubble into EX (combinational).
- perf_fwd_cnt  out  CNT_W  count of forwarded operands.
- perf_stall_cnt  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Internal records R1 (instruction in EX) and R2 (instruction in MEM); each record holds {valid, rd, we, is_load}.
- Register file is write-before-read, so the WB-stage writer needs no forwarding.
- Reset (async, rst_n=0):
  - R1 and R2 are invalid.
  - ex_sel_a and ex_sel_b are 00.
  - Counters are 0.
  - load_use_stall is 0.
- Hazard conditions:
  - hit1(rs) = R1.valid & R1.we & rs==R1.rd.
  - hit2(rs) = R2.valid & R2.we & rs==R2.rd.
  - load_use_stall = id_valid & !flush & R1.is_load & ((id_rs1_used & hit1(id_rs1)) | (id_rs2_used & hit1(id_rs2))).
- Per-operand select (computed in ID):
  - If used & hit1 & !R1.is_load, select 01.
  - Else if used & hit2, select 10.
  - Otherwise select 00.
  - R1 has priority over R2 (newest value wins).
  - 11 is never generated.
- Rising edge with pipe_en=1 (priority flush > stall > normal):
  - flush: R1 <= invalid, R2 <= R1, sels <= 00.
  - load_use_stall: R1 <= invalid (bubble), R2 <= R1, sels <= 00.
  - Normal: R1 <= {id_valid, id_rd, id_rd_we, id_is_load}, R2 <= R1, sels <= computed selects.
- pipe_en=0: records, selectors and counters hold. load_use_stall stays combinationally derived from the held state.
- Latency: selectors appear on the cycle after the instruction leaves ID, aligned with its EX cycle.
- Only the low REG_IDX_W bits are compared; no register is treated specially.
- A load-use stall lasts exactly one cycle, because the load moves into R2 and is then forwarded with select 10.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- Defined:
  - perf_fwd_cnt increments on each advancing edge (pipe_en=1, no flush, no stall) by the number of nonzero selects being loaded (0, 1 or 2).
  - perf_stall_cnt increments on each pipe_en=1 edge where load_use_stall=1.
  - Both counters wrap at 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package fwd_pkg holds:
  - Selector constants FWD_SEL_REGFILE=2'b00, FWD_SEL_EXMEM=2'b01, FWD_SEL_MEMWB=2'b10, FWD_SEL_ZERO=2'b11.
  - Packed struct dst_rec_t {valid, rd, we, is_load}.
  - REG_IDX_W default.
- One sub-module, fwd_operand_match: combinational comparator taking (rs, used, R1, R2) and returning the 2-bit select and a load-hit flag. Instantiated twice.

Test Plan:
- r1=r2+r3 then r4=r1+r5, back-to-back, pipe_en=1 -> consumer's EX cycle: ex_sel_a=01, ex_sel_b=00, stall never 1.
- Producer writes r1, one unrelated instruction, consumer reads r1 as src2 -> ex_sel_b=10.
- Load r6, next instruction reads r6 as src1 -> load_use_stall=1 for exactly one cycle; bubble EX cycle has sels 00; consumer EX cycle has ex_sel_a=10; perf_stall_cnt=1 (macro on).
- Two consecutive writers of r4, then consumer reading r4 on both sources -> ex_sel_a=ex_sel_b=01; perf_fwd_cnt +2.
- Load r7 followed by consumer of r7 with flush=1 in the same cycle -> load_use_stall=0; next sels 00; following instruction sees no forward from the squashed consumer.
- Back-to-back forward with pipe_en=0 held 3 cycles -> selects and counters unchanged. Then rst_n pulsed low mid-sequence -> immediately sels 00, stall 0, counters 0.
